// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, the 48 kHz frame period at
// 100 MHz, and the stereo pair type that both this feeder and the
// transmitter wrapper exchange.
package audio_pkg;

  localparam int SAMPLE_W         = 16;
  localparam int FRAME_CYCLES_48K = 2083;
  localparam int CNT_W            = 16;

  // One stereo sample pair as it travels through the audio path.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_t;

  // Digital silence, emitted whenever a frame finds no buffered pair.
  localparam stereo_t SILENCE = '{left: '0, right: '0};

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stereo_sample_fifo.sv
// Synchronous FIFO of stereo pairs. Full/empty are decoded from the
// occupancy register rather than from pointer comparison, so the
// pointers are plain modulo-DEPTH indices. Pushes into a full FIFO and
// pops from an empty one are ignored, which means a same-cycle push and
// pop on an empty FIFO never falls through: the pop sees empty.
module stereo_sample_fifo
  import audio_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int AFULL_LVL = 12,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  stereo_t       wdata_i,
  input  logic          pop_i,
  output stereo_t       rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o
);

  stereo_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          almost_full_q;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

  // Requests are only honoured when they cannot corrupt the occupancy.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i  && !empty_o;

  // Head of the queue is always visible; the consumer decides when to take it.
  assign rdata_o       = mem_q[rd_ptr_q];
  assign level_o       = level_q;
  assign almost_full_o = almost_full_q;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    // NOTE: default assignment first so every path drives level_d and no latch is inferred.
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage write at the tail.
  // NOTE: the array carries no reset; stale entries are unreachable because level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers, occupancy and the registered almost-full flag.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q       <= level_d;
      almost_full_q <= (level_d >= LW'(AFULL_LVL));
    end
  end

endmodule

// File: rtl/audio_frame_feeder.sv
// Stereo sample buffer and frame-rate pacer feeding the I2S transmitter.
// Pairs arrive through a ready/valid handshake into a small FIFO; the
// pacer releases exactly one pair per frame as a single-cycle valid_out
// pulse, substituting silence and counting an underrun when the FIFO is
// empty at frame time.
module audio_frame_feeder
  import audio_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = FRAME_CYCLES_48K,
  parameter int AFULL_LVL    = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] in_left,
  input  logic signed [SAMPLE_W-1:0] in_right,
  output logic signed [SAMPLE_W-1:0] sample_L,
  output logic signed [SAMPLE_W-1:0] sample_R,
  output logic                       valid_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic [CNT_W-1:0]           underrun_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             tick;

  stereo_t          fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_level;
  logic             fifo_afull;
  logic             push, pop;

  stereo_t          sample_q;
  logic             valid_q;
  logic [CNT_W-1:0] underrun_q;

  // Frame boundary: the last cycle of each FRAME_CYCLES-long frame.
  assign tick = enable && (frame_cnt_q == CNT_W'(FRAME_CYCLES - 1));

  // Handshake and frame-time pop; an empty FIFO at tick time is an underrun.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = tick && !fifo_empty;

  // Frame counter: held at zero while paused so a resume starts a fresh frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (!enable) begin
      frame_cnt_d = '0;
    end else if (tick) begin
      frame_cnt_d = '0;
    end else begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Pacer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  stereo_sample_fifo #(
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) u_fifo (
    .clk           (clk),
    .reset_n       (reset_n),
    .push_i        (push),
    .wdata_i       ('{left: in_left, right: in_right}),
    .pop_i         (pop),
    .rdata_o       (fifo_rdata),
    .level_o       (fifo_level),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .almost_full_o (fifo_afull)
  );

  // Output pair, frame strobe and underrun count all move together on tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q   <= SILENCE;
      valid_q    <= 1'b0;
      underrun_q <= '0;
    end else begin
      valid_q <= tick;
      if (tick) begin
        if (fifo_empty) begin
          sample_q   <= SILENCE;
          underrun_q <= sat_inc(underrun_q);
        end else begin
          sample_q <= fifo_rdata;
        end
      end
    end
  end

  assign sample_L     = sample_q.left;
  assign sample_R     = sample_q.right;
  assign valid_out    = valid_q;
  assign level        = fifo_level;
  assign almost_full  = fifo_afull;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_audio_frame_feeder.sv
// Self-checking bench for audio_frame_feeder: a fill table, directed
// multi-cycle sequences and randomized traffic, all compared every cycle
// against a queue-based model of the frame/FIFO rules.
module tb_audio_frame_feeder;

  localparam int FC    = 1056;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        in_ready;
  logic [15:0] sample_L, sample_R;
  logic        valid_out;
  logic [4:0]  level;
  logic        almost_full;
  logic [15:0] underrun_cnt;

  audio_frame_feeder #(
    .DEPTH        (DEPTH),
    .FRAME_CYCLES (FC),
    .AFULL_LVL    (AF)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_left      (in_left),
    .in_right     (in_right),
    .sample_L     (sample_L),
    .sample_R     (sample_R),
    .valid_out    (valid_out),
    .level        (level),
    .almost_full  (almost_full),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: queued pairs, enabled-cycle run length, outputs.
  logic [31:0] mq[$];
  int          run  = 0;
  int          m_ur = 0;
  logic [15:0] m_l  = '0;
  logic [15:0] m_r  = '0;
  logic        m_valid = 1'b0;

  // Last observed pulse.
  bit          pulse_seen = 0;
  int          pulse_cyc  = 0;
  logic [15:0] pulse_l, pulse_r;

  typedef struct {
    logic        iv;
    logic [15:0] l;
    logic [15:0] r;
    int          exp_level;
    logic        exp_ready;
    logic        exp_afull;
  } vec_t;
  vec_t fill_tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    run = 0; m_ur = 0; m_l = '0; m_r = '0; m_valid = 1'b0;
  endtask

  // One clock edge of the frame rules: a frame ends every FC enabled
  // cycles; it takes the oldest pair (or silence on an empty queue), and a
  // pair offered while the queue had room joins the back afterwards.
  task automatic model_edge();
    bit tick;
    int pre;
    tick = enable && ((run % FC) == FC - 1);
    pre  = mq.size();
    m_valid = tick;
    if (tick) begin
      if (pre > 0) begin
        {m_l, m_r} = mq.pop_front();
      end else begin
        m_l = '0; m_r = '0;
        if (m_ur < 65535) m_ur++;
      end
    end
    if (in_valid && pre < DEPTH) mq.push_back({in_left, in_right});
    run = enable ? run + 1 : 0;
  endtask

  task automatic compare_all();
    check("valid_out",    32'(valid_out),    32'(m_valid));
    check("sample_L",     32'(sample_L),     32'(m_l));
    check("sample_R",     32'(sample_R),     32'(m_r));
    check("level",        32'(level),        32'(mq.size()));
    check("almost_full",  32'(almost_full),  32'(mq.size() >= AF));
    check("in_ready",     32'(in_ready),     32'(mq.size() < DEPTH));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_ur));
  endtask

  task automatic step(input logic en, input logic iv, input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    enable = en; in_valid = iv; in_left = l; in_right = r;
    if (reset_n) model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    if (valid_out) begin
      pulse_seen = 1; pulse_cyc = cyc; pulse_l = sample_L; pulse_r = sample_R;
    end
  endtask

  task automatic run_until_pulse(input int max);
    pulse_seen = 0;
    for (int i = 0; i < max && !pulse_seen; i++) step(1'b1, 1'b0, '0, '0);
    check("pulse_timeout", 32'(pulse_seen), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},  32'(valid_out),    32'd0);
    check({tag, "_L"},      32'(sample_L),     32'd0);
    check({tag, "_R"},      32'(sample_R),     32'd0);
    check({tag, "_level"},  32'(level),        32'd0);
    check({tag, "_afull"},  32'(almost_full),  32'd0);
    check({tag, "_ur"},     32'(underrun_cnt), 32'd0);
    check({tag, "_ready"},  32'(in_ready),     32'd1);
  endtask

  // Asynchronous reset mid-cycle with a push offered throughout.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0; enable = 1'b1; in_valid = 1'b1; in_left = 16'hDEAD; in_right = 16'hBEEF;
    #1;
    check_reset_vals("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk);
    reset_n = 1'b1; enable = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int prob [4];
    int len  [4];

    for (int i = 0; i < 17; i++) begin
      fill_tbl[i].iv        = 1'b1;
      fill_tbl[i].l         = 16'h1000 + 16'(i);
      fill_tbl[i].r         = 16'h2000 + 16'(i);
      fill_tbl[i].exp_level = (i < DEPTH) ? i + 1 : DEPTH;
      fill_tbl[i].exp_ready = (i < DEPTH - 1);
      fill_tbl[i].exp_afull = (fill_tbl[i].exp_level >= AF);
    end

    // Reset state.
    #1;
    check_reset_vals("por");
    apply_reset();

    // Three pairs in order, then an underrun frame.
    step(1'b0, 1'b1, 16'h1111, 16'h2222);
    step(1'b0, 1'b1, 16'h3333, 16'h4444);
    step(1'b0, 1'b1, 16'h5555, 16'h6666);
    e = cyc;
    run_until_pulse(FC + 4);
    check("a_p0_time", 32'(pulse_cyc), 32'(e + FC));
    check("a_p0_L", 32'(pulse_l), 32'h1111);
    check("a_p0_R", 32'(pulse_r), 32'h2222);
    e = pulse_cyc;
    run_until_pulse(FC + 4);
    check("a_p1_time", 32'(pulse_cyc), 32'(e + FC));
    check("a_p1_L", 32'(pulse_l), 32'h3333);
    check("a_p1_R", 32'(pulse_r), 32'h4444);
    e = pulse_cyc;
    run_until_pulse(FC + 4);
    check("a_p2_time", 32'(pulse_cyc), 32'(e + FC));
    check("a_p2_L", 32'(pulse_l), 32'h5555);
    check("a_p2_R", 32'(pulse_r), 32'h6666);
    e = pulse_cyc;
    run_until_pulse(FC + 4);
    check("a_p3_time", 32'(pulse_cyc), 32'(e + FC));
    check("a_p3_L", 32'(pulse_l), 32'h0);
    check("a_p3_R", 32'(pulse_r), 32'h0);
    check("a_ur", 32'(underrun_cnt), 32'd1);
    check("a_level", 32'(level), 32'd0);

    // Fill to full with the pacer stopped; the 17th offer is refused.
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b0, fill_tbl[i].iv, fill_tbl[i].l, fill_tbl[i].r);
      check("fill_level", 32'(level),       32'(fill_tbl[i].exp_level));
      check("fill_ready", 32'(in_ready),    32'(fill_tbl[i].exp_ready));
      check("fill_afull", 32'(almost_full), 32'(fill_tbl[i].exp_afull));
    end
    run_until_pulse(FC + 4);
    check("b_p0_L", 32'(pulse_l), 32'(fill_tbl[0].l));
    check("b_p0_R", 32'(pulse_r), 32'(fill_tbl[0].r));
    check("b_level", 32'(level), 32'd15);
    check("b_ready", 32'(in_ready), 32'd1);
    step(1'b1, 1'b0, '0, '0);
    check("b_ready_next", 32'(in_ready), 32'd1);

    // Almost-full threshold: rises after the 12th push, falls on first pop.
    apply_reset();
    for (int i = 0; i < AF; i++) begin
      step(1'b0, 1'b1, 16'(i), 16'(~i));
      check("c_afull", 32'(almost_full), 32'(i == AF - 1));
    end
    run_until_pulse(FC + 4);
    check("c_level_pop", 32'(level), 32'd11);
    check("c_afull_pop", 32'(almost_full), 32'd0);

    // Push on the very tick that finds the FIFO empty: no fall-through.
    apply_reset();
    e = cyc;
    for (int i = 0; i < FC - 1; i++) step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 16'hA5A5, 16'h5A5A);
    check("d_valid", 32'(valid_out), 32'd1);
    check("d_time", 32'(cyc), 32'(e + FC));
    check("d_L", 32'(sample_L), 32'd0);
    check("d_ur", 32'(underrun_cnt), 32'd1);
    check("d_level", 32'(level), 32'd1);
    e = cyc;
    run_until_pulse(FC + 4);
    check("d_next_time", 32'(pulse_cyc), 32'(e + FC));
    check("d_next_L", 32'(pulse_l), 32'hA5A5);
    check("d_next_R", 32'(pulse_r), 32'h5A5A);
    check("d_next_ur", 32'(underrun_cnt), 32'd1);

    // Pause at count 500 for 10 cycles: the partial frame is discarded.
    apply_reset();
    pulse_seen = 0;
    for (int i = 0; i < 500; i++) step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++)  step(1'b0, 1'b0, '0, '0);
    check("e_no_pulse", 32'(pulse_seen), 32'd0);
    e = cyc;
    run_until_pulse(FC + 4);
    check("e_time", 32'(pulse_cyc), 32'(e + FC));

    // Reset mid-frame with five pairs queued and a non-zero output held.
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h7000 + 16'(i), 16'h0700 + 16'(i));
    run_until_pulse(FC + 4);
    check("f_p0_L", 32'(pulse_l), 32'h7000);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, '0, '0);
    check("f_level_pre", 32'(level), 32'd5);
    apply_reset();
    run_until_pulse(FC + 4);
    check("f_after_L", 32'(pulse_l), 32'd0);
    check("f_after_ur", 32'(underrun_cnt), 32'd1);

    // Randomized traffic: fill, moderate, drain and mixed phases with rare pauses.
    apply_reset();
    prob[0] = 6; prob[1] = 1; prob[2] = 0; prob[3] = 3;
    len[0] = 3000; len[1] = 4000; len[2] = 6000; len[3] = 3000;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < len[b]; i++) begin
        step(logic'($urandom_range(0, 2999) != 0),
             logic'($urandom_range(0, 999) < prob[b]),
             16'($urandom), 16'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
